// File: rtl/lsu.sv
// Load/store unit: turns decoded load/store requests into single req/ack
// data-memory transactions and returns aligned, extended load data.
// The core is stalled while a transaction is open.
module lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [2:0]  loadops,
  input  logic [1:0]  storeops,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [1:0]  lane_q, lane_n;
  logic [1:0]  size_q, size_n;
  logic        sign_q, sign_n;

  logic        req_n, we_n, ld_valid_n, misalign_n, bus_err_n;
  logic [31:0] addr_n, wdata_n, ld_data_n;
  logic [3:0]  be_n;

  logic        is_store, is_load, op, aligned, dec_we, dec_sign;
  logic [1:0]  dec_size;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;
  logic [31:0] lane_word, ext_data;
  logic [15:0] half_val;

  // Decode the incoming request: store wins over load, size/sign, alignment, lanes.
  always_comb begin
    is_store = memwrite && (storeops != 2'd0);
    is_load  = (loadops != 3'b111);
    op       = in_valid && (is_load || is_store);
    dec_we   = is_store;
    dec_sign = 1'b0;
    dec_size = SZ_W;
    if (is_store) begin
      case (storeops)
        2'd1:    dec_size = SZ_B;
        2'd2:    dec_size = SZ_H;
        default: dec_size = SZ_W;
      endcase
    end else begin
      dec_sign = ~loadops[2];
      case (loadops[1:0])
        2'b00:   dec_size = SZ_B;
        2'b01:   dec_size = SZ_H;
        default: dec_size = SZ_W;
      endcase
    end
    case (dec_size)
      SZ_B: begin
        aligned   = 1'b1;
        dec_be    = 4'b0001 << addr[1:0];
        dec_wdata = {4{wdata[7:0]}};
      end
      SZ_H: begin
        aligned   = ~addr[0];
        dec_be    = addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{wdata[15:0]}};
      end
      default: begin
        aligned   = (addr[1:0] == 2'b00);
        dec_be    = 4'b1111;
        dec_wdata = wdata;
      end
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    lane_word = mem_rdata >> {lane_q, 3'b000};
    half_val  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_B:    ext_data = {{24{lane_word[7] & sign_q}}, lane_word[7:0]};
      SZ_H:    ext_data = {{16{half_val[15] & sign_q}}, half_val};
      default: ext_data = mem_rdata;
    endcase
  end

  assign stall = ((state == IDLE) && op && aligned) || (state == BUS);

  // Next-state and next-output logic for the IDLE -> BUS -> DONE sequence.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lane_n     = lane_q;
    size_n     = size_q;
    sign_n     = sign_q;
    req_n      = mem_req;
    we_n       = mem_we;
    addr_n     = mem_addr;
    be_n       = mem_be;
    wdata_n    = mem_wdata;
    ld_data_n  = ld_data;
    ld_valid_n = 1'b0;
    misalign_n = 1'b0;
    bus_err_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = 8'd0;
        if (op && aligned) begin
          lane_n  = addr[1:0];
          size_n  = dec_size;
          sign_n  = dec_sign;
          we_n    = dec_we;
          addr_n  = {addr[31:2], 2'b00};
          be_n    = dec_be;
          wdata_n = dec_wdata;
          req_n   = 1'b1;
          state_n = BUS;
        end else if (op) begin
          misalign_n = 1'b1;
        end
      end
      BUS: begin
        if (mem_ack) begin
          req_n = 1'b0;
          if (!mem_we) begin
            ld_data_n  = ext_data;
            ld_valid_n = 1'b1;
          end
          state_n = DONE;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          req_n     = 1'b0;
          bus_err_n = 1'b1;
          state_n   = DONE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DONE: begin
        cnt_n   = 8'd0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered bus/result outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      lane_q    <= 2'd0;
      size_q    <= SZ_B;
      sign_q    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      ld_data   <= 32'd0;
      ld_valid  <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lane_q    <= lane_n;
      size_q    <= size_n;
      sign_q    <= sign_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_be    <= be_n;
      mem_wdata <= wdata_n;
      ld_data   <= ld_data_n;
      ld_valid  <= ld_valid_n;
      misalign  <= misalign_n;
      bus_err   <= bus_err_n;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: table of single transactions plus hand-written
// sequences for timeout, ack-on-last-cycle, stray ack and reset mid-bus.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  loadops;
  logic [1:0]  storeops;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  lo;
    logic [1:0]  so;
    logic        mw;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          nwait;
    logic        mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;
  } vec_t;

  // kind: 0 ld_valid, 1 misalign, 2 bus_err
  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  vec_t vecs[$];
  ev_t  sb[$];

  lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .loadops(loadops),
    .storeops(storeops), .memwrite(memwrite), .addr(addr), .wdata(wdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .misalign(misalign),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] lo, input logic [1:0] so, input logic mw,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input int nw, input logic mis, input logic [31:0] ea,
                              input logic [3:0] eb, input logic ew, input logic [31:0] ewd,
                              input logic [31:0] eld);
    vec_t v;
    v.lo = lo; v.so = so; v.mw = mw; v.a = a; v.wd = wd; v.rd = rd; v.nwait = nw;
    v.mis = mis; v.e_addr = ea; v.e_be = eb; v.e_we = ew; v.e_wdata = ewd; v.e_ld = eld;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    in_valid = 1'b0;
    loadops  = 3'b111;
    storeops = 2'd0;
    memwrite = 1'b0;
    addr     = 32'd0;
    wdata    = 32'd0;
  endtask

  task automatic driveOp(input logic [2:0] lo, input logic [1:0] so, input logic mw,
                         input logic [31:0] a, input logic [31:0] wd);
    in_valid = 1'b1;
    loadops  = lo;
    storeops = so;
    memwrite = mw;
    addr     = a;
    wdata    = wd;
  endtask

  // Every pulse output must match the oldest expected event on the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    int  k;
    int  npulse;
    if (ld_valid === 1'b1 || misalign === 1'b1 || bus_err === 1'b1) begin
      total++;
      npulse = int'(ld_valid) + int'(misalign) + int'(bus_err);
      k = ld_valid ? 0 : (misalign ? 1 : 2);
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_pulse: ld_valid=%0b misalign=%0b bus_err=%0b required none",
                 ld_valid, misalign, bus_err);
      end else begin
        e = sb.pop_front();
        if (npulse != 1 || k != e.kind || (k == 0 && ld_data !== e.data)) begin
          bad++;
          $display("[TB] FAIL pulse_event: got kind=%0d n=%0d data=%h required kind=%0d data=%h",
                   k, npulse, ld_data, e.kind, e.data);
        end
      end
    end
  end

  // One table entry: accept, serve bus with optional wait states, check result.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    driveOp(v.lo, v.so, v.mw, v.a, v.wd);
    if (v.mis) sb.push_back('{1, 32'd0});
    else if (!v.e_we) sb.push_back('{0, v.e_ld});
    #1 checkOutput("stall_accept", {31'd0, stall}, {31'd0, !v.mis});
    @(negedge clk);
    idleInputs();
    checkOutput("mem_req_start", {31'd0, mem_req}, {31'd0, !v.mis});
    if (v.mis) begin
      checkOutput("stall_mis", {31'd0, stall}, 32'd0);
      @(negedge clk);
      checkOutput("mem_req_mis", {31'd0, mem_req}, 32'd0);
    end else begin
      checkOutput("mem_addr", mem_addr, v.e_addr);
      checkOutput("mem_be", {28'd0, mem_be}, {28'd0, v.e_be});
      checkOutput("mem_we", {31'd0, mem_we}, {31'd0, v.e_we});
      if (v.e_we) checkOutput("mem_wdata", mem_wdata, v.e_wdata);
      for (int i = 0; i < v.nwait; i++) begin
        @(negedge clk);
        checkOutput("req_hold", {31'd0, mem_req}, 32'd1);
        checkOutput("stall_bus", {31'd0, stall}, 32'd1);
      end
      if (v.nwait > 0) checkOutput("addr_hold", mem_addr, v.e_addr);
      mem_ack   = 1'b1;
      mem_rdata = v.rd;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      checkOutput("req_done", {31'd0, mem_req}, 32'd0);
      checkOutput("stall_done", {31'd0, stall}, 32'd0);
      checkOutput("ld_valid_latency", {31'd0, ld_valid}, {31'd0, !v.e_we});
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    idleInputs();

    vecs.push_back(mk(3'b111, 2'd3, 1'b1, 32'h104, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'h104, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(3'b111, 2'd1, 1'b1, 32'h103, 32'h000000A5, 32'h0, 0, 1'b0, 32'h100, 4'b1000, 1'b1, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(3'b000, 2'd0, 1'b0, 32'h102, 32'h0, 32'h00807F00, 0, 1'b0, 32'h100, 4'b0100, 1'b0, 32'h0, 32'hFFFFFF80));
    vecs.push_back(mk(3'b100, 2'd0, 1'b0, 32'h102, 32'h0, 32'h00807F00, 1, 1'b0, 32'h100, 4'b0100, 1'b0, 32'h0, 32'h00000080));
    vecs.push_back(mk(3'b001, 2'd0, 1'b0, 32'h101, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(3'b001, 2'd0, 1'b0, 32'h102, 32'h0, 32'h80011234, 0, 1'b0, 32'h100, 4'b1100, 1'b0, 32'h0, 32'hFFFF8001));
    vecs.push_back(mk(3'b101, 2'd0, 1'b0, 32'h100, 32'h0, 32'h8001F00D, 2, 1'b0, 32'h100, 4'b0011, 1'b0, 32'h0, 32'h0000F00D));
    vecs.push_back(mk(3'b010, 2'd0, 1'b0, 32'h208, 32'h0, 32'h12345678, 3, 1'b0, 32'h208, 4'b1111, 1'b0, 32'h0, 32'h12345678));
    vecs.push_back(mk(3'b111, 2'd2, 1'b1, 32'h10A, 32'h1234BEEF, 32'h0, 2, 1'b0, 32'h108, 4'b1100, 1'b1, 32'hBEEFBEEF, 32'h0));
    vecs.push_back(mk(3'b111, 2'd3, 1'b1, 32'h102, 32'h11223344, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(3'b000, 2'd0, 1'b0, 32'h101, 32'h0, 32'h00007F00, 0, 1'b0, 32'h100, 4'b0010, 1'b0, 32'h0, 32'h0000007F));
    vecs.push_back(mk(3'b010, 2'd1, 1'b1, 32'h101, 32'h00000011, 32'h0, 0, 1'b0, 32'h100, 4'b0010, 1'b1, 32'h11111111, 32'h0));
    vecs.push_back(mk(3'b111, 2'd2, 1'b1, 32'h103, 32'h0000ABCD, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(3'b001, 2'd0, 1'b0, 32'h106, 32'h0, 32'h7FFF0000, 0, 1'b0, 32'h104, 4'b1100, 1'b0, 32'h0, 32'h00007FFF));
    vecs.push_back(mk(3'b000, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80000000, 1, 1'b0, 32'h100, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80));

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_pulses", {29'd0, ld_valid, misalign, bus_err}, 32'd0);
    checkOutput("rst_ld_data", ld_data, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_be", {28'd0, mem_be}, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Store without memwrite qualifier is not an operation.
    @(negedge clk);
    driveOp(3'b111, 2'd3, 1'b0, 32'h104, 32'h12345678);
    #1 checkOutput("noop_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    idleInputs();
    checkOutput("noop_mem_req", {31'd0, mem_req}, 32'd0);

    // Stray ack while idle must be ignored.
    mem_ack = 1'b1;
    mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("stray_ack_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    checkOutput("stray_ack_ld_valid", {31'd0, ld_valid}, 32'd0);

    // Timeout: no ack, mem_req must stay up exactly 16 cycles then bus_err.
    @(negedge clk);
    driveOp(3'b010, 2'd0, 1'b0, 32'h300, 32'h0);
    sb.push_back('{2, 32'd0});
    #1 checkOutput("to_stall_accept", {31'd0, stall}, 32'd1);
    @(negedge clk);
    idleInputs();
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput("to_req_cycles", n, 32'd16);
    checkOutput("to_bus_err", {31'd0, bus_err}, 32'd1);
    checkOutput("to_stall_done", {31'd0, stall}, 32'd0);
    @(negedge clk);

    // Ack in the 16th bus cycle wins over the timeout.
    driveOp(3'b010, 2'd0, 1'b0, 32'h400, 32'h0);
    sb.push_back('{0, 32'hCAFEF00D});
    @(negedge clk);
    idleInputs();
    repeat (15) @(negedge clk);
    checkOutput("aw_req_last", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("aw_ld_valid", {31'd0, ld_valid}, 32'd1);
    checkOutput("aw_bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);

    // Reset during BUS with an ack pending: no result, bus released.
    driveOp(3'b010, 2'd0, 1'b0, 32'h500, 32'h0);
    @(negedge clk);
    idleInputs();
    checkOutput("rb_req_up", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h87654321;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b0;
    checkOutput("rb_req_down", {31'd0, mem_req}, 32'd0);
    checkOutput("rb_stall", {31'd0, stall}, 32'd0);
    checkOutput("rb_ld_valid", {31'd0, ld_valid}, 32'd0);
    @(negedge clk);
    checkOutput("rb_ld_valid_after", {31'd0, ld_valid}, 32'd0);
    checkOutput("rb_req_after", {31'd0, mem_req}, 32'd0);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drain", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
